// File: rtl/imem_loader.sv
// Boot loader: clears instruction memory, assembles little-endian words from a
// byte stream, writes them from address 0 upward and then releases the core.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; core_hold keeps its last value
// S_CLEAR | one-cycle instruction memory clear strobe
// S_RECV  | accepting stream bytes into the current word
// S_WRITE | one-cycle write of the assembled word
// S_FIN   | one-cycle done pulse; core released
module imem_loader #(
    parameter int PC_SIZE = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_SIZE:0]   num_words,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_clear,
    output logic               imem_we,
    output logic [PC_SIZE-1:0] imem_addr,
    output logic [31:0]        imem_data,
    output logic               core_hold,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [PC_SIZE:0] CAPACITY = {1'b1, {PC_SIZE{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RECV, S_WRITE, S_FIN} state_t;

    state_t             state, state_nxt;
    logic [PC_SIZE:0]   count_q;
    logic [PC_SIZE:0]   word_cnt;
    logic [PC_SIZE:0]   word_nxt;
    logic [1:0]         byte_cnt;
    logic [23:0]        asm_q;
    logic [PC_SIZE-1:0] addr_q;
    logic [31:0]        data_q;
    logic               hold_q;
    logic               accept;

    assign word_nxt = word_cnt + 1'b1;
    assign accept   = (state == S_RECV) && byte_valid;

    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && (num_words <= CAPACITY)) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = (count_q == '0) ? S_FIN : S_RECV;
            S_RECV:  if (accept && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (word_nxt == count_q) ? S_FIN : S_RECV;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == S_RECV);
        imem_clear = (state == S_CLEAR);
        imem_we    = (state == S_WRITE);
        busy       = (state != S_IDLE);
        done       = (state == S_FIN);
        // Release is visible in the FIN cycle itself, not one cycle later.
        core_hold  = hold_q && (state != S_FIN);
    end

    assign imem_addr = addr_q;
    assign imem_data = data_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q  <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            hold_q   <= 1'b1;
            error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_words > CAPACITY) begin
                            error <= 1'b1;
                        end else begin
                            count_q <= num_words;
                            error   <= 1'b0;
                            hold_q  <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    word_cnt <= '0;
                    byte_cnt <= '0;
                end
                S_RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_q[7:0]   <= byte_in;
                            2'd1: asm_q[15:8]  <= byte_in;
                            2'd2: asm_q[23:16] <= byte_in;
                            default: begin
                                // Last lane goes straight to the write register.
                                addr_q <= word_cnt[PC_SIZE-1:0];
                                data_q <= {byte_in, asm_q};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_cnt <= word_nxt;
                    byte_cnt <= '0;
                end
                S_FIN: hold_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time controller that fills the instruction memory of the fetch stage from an 8-bit byte stream.
- Holds the core in reset while loading.
- Sequence: clear memory, assemble little-endian 32-bit words, write them to consecutive addresses from 0, then release the core.
- Sits between the external load port and the instruction memory write side (write address, write data, clear) plus the fetch/pipeline reset.

Parameters:
PC_SIZE, 10, instruction memory address width; capacity = 2^PC_SIZE words

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  single-cycle request to begin a load; sampled only in IDLE
num_words  input  PC_SIZE+1  words to load; sampled with start
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte this cycle
imem_clear  output  1  one-cycle instruction memory clear strobe
imem_we  output  1  one-cycle instruction memory write strobe
imem_addr  output  PC_SIZE  write address
imem_data  output  32  write data
core_hold  output  1  active-high; holds fetch/pipeline in reset
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a load completes
error  output  1  sticky: last start carried num_words > 2^PC_SIZE

Behaviour:
- Reset (reset==0 at an edge, regardless of state):
  - state IDLE, core_hold=1, all other outputs 0.
  - Word counter, byte counter and assembly register cleared; error cleared.
  - A load in progress is abandoned with no further writes; memory contents are left as is.
- States: IDLE, CLEAR, RECV, WRITE, FIN.
- IDLE:
  - byte_ready=0.
  - start=1 with num_words <= 2^PC_SIZE: latch num_words, clear error, assert core_hold, go to CLEAR.
  - start=1 with num_words > 2^PC_SIZE: set error=1, no other effect, stay IDLE; core_hold unchanged.
  - start while not IDLE is ignored.
- CLEAR (exactly one cycle): imem_clear=1.
  - Latched count = 0: next state FIN.
  - Otherwise: next state RECV; word counter=0, byte counter=0.
- RECV: byte_ready=1.
  - On byte_valid&&byte_ready, store byte_in into lane byte counter (byte 0 -> bits[7:0], byte 3 -> bits[31:24]) and increment byte counter.
  - The 4th accepted byte moves to WRITE.
  - byte_valid low: stall with no state change and no timeout.
- WRITE (exactly one cycle): byte_ready=0, imem_we=1, imem_addr=word counter[PC_SIZE-1:0], imem_data=assembled word.
  - Then increment word counter and reset byte counter.
  - Next state is FIN if the incremented count equals the latched count, else RECV.
- FIN (one cycle): done=1, core_hold deasserts (0 from this cycle on, until next accepted start or reset). Next state IDLE.
- busy=1 in CLEAR, RECV, WRITE and FIN.
- Throughput: one bubble per word, so a word takes 5 cycles minimum.
- Latency: start accepted at edge t gives imem_clear high in cycle t+1. First byte can be accepted in cycle t+2.
- Full-capacity load (num_words = 2^PC_SIZE): last write at address 2^PC_SIZE-1. The counter is PC_SIZE+1 wide and does not wrap before the compare.
- imem_addr/imem_data hold their last values outside WRITE; they are meaningful only while imem_we=1.

Test Plan:
- Reset then idle 5 cycles -> core_hold=1, busy=0, done=0, error=0, imem_we=0, imem_clear=0, byte_ready=0.
- start, num_words=2, bytes 13 00 50 00 93 00 10 00 every cycle -> imem_clear one cycle after start. Writes addr0=0x00500013 and addr1=0x00100093, 5 cycles apart. Then done pulse, core_hold=0, busy=0.
- num_words=1 with byte_valid toggling 1,0,0,1,1,0,1 -> only the 4 valid bytes captured in order; exactly one imem_we; data correct.
- num_words=0 -> sequence CLEAR, FIN, IDLE: one imem_clear, no imem_we, done two cycles after start.
- num_words=1025 (PC_SIZE=10) -> error=1, busy stays 0, no strobes. A following start with num_words=1 clears error and loads normally.
- reset low after 2 bytes of word 0; and separately, start pulsed during RECV -> reset returns to IDLE with core_hold=1, no write, error=0. The mid-load start has no effect on the load in progress.
